// File: rtl/shake_padder_if.sv
// Message-in / padded-block-out handshake bundle for shake_padder.
// The slave modport is the padder's view; the master modport is the producer/consumer side.
interface shake_padder_if;
    logic          msg_valid;
    logic          msg_ready;
    logic [63:0]   msg_data;
    logic [3:0]    msg_bytes;
    logic          msg_last;
    logic [1599:0] block_out;
    logic          block_valid;
    logic          block_ready;
    logic          block_last;

    modport slave (
        input  msg_valid, msg_data, msg_bytes, msg_last, block_ready,
        output msg_ready, block_out, block_valid, block_last
    );

    modport master (
        output msg_valid, msg_data, msg_bytes, msg_last, block_ready,
        input  msg_ready, block_out, block_valid, block_last
    );
endinterface

// File: rtl/shake_padder.sv
// Packs 64-bit message words into 136-byte rate blocks and applies Keccak pad10*1 with a domain suffix.
// Macro SHAKE_PADDER_SHA3_EN selects the SHA3 suffix 0x06; the default build uses the SHAKE256 suffix 0x1F.
module shake_padder (
    input  logic           clk,
    input  logic           reset,
    shake_padder_if.slave  bus,
    output logic [1:0]     debug_state
);

`ifdef SHAKE_PADDER_SHA3_EN
    localparam logic [7:0] SUFFIX = 8'h06;
`else
    localparam logic [7:0] SUFFIX = 8'h1F;
`endif

    typedef enum logic [1:0] {
        S_FILL      = 2'd0,
        S_EMIT      = 2'd1,
        S_PADONLY   = 2'd2,
        S_EMIT_LAST = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    lane_q, lane_d;
    logic [1087:0] buf_q, buf_d;
    logic          pad_pend_q, pad_pend_d;

    logic [3:0]    bytes_eff;
    logic [63:0]   word_m;
    logic [7:0]    p;
    logic [10:0]   lidx;
    logic [10:0]   pidx;
    logic          hs;

    assign bus.msg_ready   = (state_q == S_FILL) && !reset;
    assign bus.block_valid = (state_q == S_EMIT) || (state_q == S_EMIT_LAST);
    assign bus.block_last  = (state_q == S_EMIT_LAST);
    assign bus.block_out   = {512'b0, buf_q};
    assign debug_state     = state_q;

    assign hs        = bus.msg_valid && bus.msg_ready;
    assign bytes_eff = (bus.msg_bytes > 4'd8) ? 4'd8 : bus.msg_bytes;
    assign p         = {lane_q, 3'b000} + {4'b0000, bytes_eff};
    assign lidx      = {lane_q, 6'b000000};
    assign pidx      = {p, 3'b000};

    always_comb begin
        word_m = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < 32'(bytes_eff)) begin
                word_m[8*k +: 8] = bus.msg_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        buf_d      = buf_q;
        pad_pend_d = pad_pend_q;
        case (state_q)
            S_FILL: begin
                if (hs) begin
                    buf_d[lidx +: 64] = word_m;
                    if (bus.msg_last) begin
                        if (p == 8'd136) begin
                            // Message filled the rate exactly: padding goes in a block of its own.
                            state_d    = S_EMIT;
                            pad_pend_d = 1'b1;
                        end else begin
                            buf_d[pidx +: 8]   = buf_d[pidx +: 8] ^ SUFFIX;
                            buf_d[1087:1080]   = buf_d[1087:1080] ^ 8'h80;
                            state_d            = S_EMIT_LAST;
                        end
                    end else if (lane_q == 5'd16) begin
                        state_d = S_EMIT;
                    end else begin
                        lane_d = lane_q + 5'd1;
                    end
                end
            end
            S_EMIT: begin
                if (bus.block_ready) begin
                    buf_d      = '0;
                    lane_d     = '0;
                    pad_pend_d = 1'b0;
                    state_d    = pad_pend_q ? S_PADONLY : S_FILL;
                end
            end
            S_PADONLY: begin
                buf_d            = '0;
                buf_d[7:0]       = SUFFIX;
                buf_d[1087:1080] = 8'h80;
                state_d          = S_EMIT_LAST;
            end
            S_EMIT_LAST: begin
                if (bus.block_ready) begin
                    buf_d   = '0;
                    lane_d  = '0;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FILL;
            lane_q     <= '0;
            buf_q      <= '0;
            pad_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            buf_q      <= buf_d;
            pad_pend_q <= pad_pend_d;
        end
    end

endmodule

// File: tb/tb_shake_padder.sv
// Scoreboard bench for shake_padder: directed messages push expected blocks, a monitor pops on acceptance.
module tb_shake_padder;

`ifdef SHAKE_PADDER_SHA3_EN
    localparam logic [7:0] SUF = 8'h06;
`else
    localparam logic [7:0] SUF = 8'h1F;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] debug_state;
    int         n_vec = 0;
    int         n_err = 0;
    logic [1600:0] sb_q[$];

    shake_padder_if bus ();

    shake_padder dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .debug_state (debug_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pb(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [63:0] pat_word(input int n);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = pb(8*n + k);
        return w;
    endfunction

    // Expected block for a message of len pattern bytes (len 0 gives the pad-only block).
    function automatic logic [1599:0] mk_block(input int len);
        logic [1599:0] b;
        b = '0;
        for (int i = 0; i < len; i++) b[8*i +: 8] = pb(i);
        if (len < 136) begin
            b[8*len +: 8]  = b[8*len +: 8] ^ SUF;
            b[1087:1080]   = b[1087:1080] ^ 8'h80;
        end
        return b;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_blk(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        n_vec++;
        if (act !== exp) begin
            int j;
            n_err++;
            j = 0;
            while (j < 199 && act[8*j +: 8] === exp[8*j +: 8]) j++;
            $display("FAIL %s: first differing byte %0d got %h expected %h at %0t",
                     name, j, act[8*j +: 8], exp[8*j +: 8], $time);
        end
    endtask

    task automatic push_exp(input logic [1599:0] b, input logic last);
        sb_q.push_back({last, b});
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_word(input logic [63:0] d, input logic [3:0] b, input logic l);
        int unsigned t = 0;
        bus.msg_valid = 1'b1;
        bus.msg_data  = d;
        bus.msg_bytes = b;
        bus.msg_last  = l;
        while (!bus.msg_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.msg_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: msg_ready stayed %b expected 1", bus.msg_ready);
        end
        @(negedge clk);
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d blocks outstanding expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic wait_valid(input string name);
        int unsigned t = 0;
        while (!bus.block_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_bit({name, "_valid"}, bus.block_valid, 1'b1);
    endtask

    // Monitor: compares at negedge+1 so same-negedge ready changes by the driver are settled.
    initial begin
        logic [1600:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && bus.block_valid && bus.block_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_block: block_valid %b with empty scoreboard at %0t",
                             bus.block_valid, $time);
                end else begin
                    e = sb_q.pop_front();
                    check_blk("blk_out", bus.block_out, e[1599:0]);
                    check_bit("blk_last", bus.block_last, e[1600]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        logic [1599:0] exp, snap;
        reset           = 1'b1;
        bus.msg_valid   = 1'b0;
        bus.msg_data    = '0;
        bus.msg_bytes   = '0;
        bus.msg_last    = 1'b0;
        bus.block_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("rst_msg_ready", bus.msg_ready, 1'b0);
        check_bit("rst_valid", bus.block_valid, 1'b0);
        check_bit("rst_last", bus.block_last, 1'b0);
        check_blk("rst_out", bus.block_out, '0);
        check_bit("rst_dbg", debug_state == 2'd0, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check_bit("idle_msg_ready", bus.msg_ready, 1'b1);

        // Empty message
        push_exp(mk_block(0), 1'b1);
        send_word(64'h0, 4'd0, 1'b1);
        drain("empty");

        // "abc"
        exp = '0;
        exp[7:0] = 8'h61; exp[15:8] = 8'h62; exp[23:16] = 8'h63;
        exp[31:24] = SUF; exp[1087:1080] = 8'h80;
        push_exp(exp, 1'b1);
        send_word(64'h636261, 4'd3, 1'b1);
        drain("abc");

        // 135 bytes; stray data in the unused top byte must be dropped
        push_exp(mk_block(135), 1'b1);
        for (int n = 0; n < 17; n++)
            send_word(pat_word(n), (n == 16) ? 4'd7 : 4'd8, n == 16);
        drain("len135");

        // 136 bytes: data block then pad-only block, no input accepted in between
        push_exp(mk_block(136), 1'b0);
        push_exp(mk_block(0), 1'b1);
        for (int n = 0; n < 17; n++)
            send_word(pat_word(n), 4'd8, n == 16);
        for (int t = 0; t < 20 && sb_q.size() != 0; t++) begin
            check_bit("len136_msg_ready", bus.msg_ready, 1'b0);
            @(negedge clk);
        end
        drain("len136");

        // Backpressure: block held 5 cycles, then next word lands in lane 0
        bus.block_ready = 1'b0;
        exp = '0;
        exp[7:0] = 8'h61; exp[15:8] = 8'h62; exp[23:16] = 8'h63;
        exp[31:24] = SUF; exp[1087:1080] = 8'h80;
        push_exp(exp, 1'b1);
        send_word(64'hFFEE_DDCC_BB63_6261, 4'd3, 1'b1);
        wait_valid("hold");
        snap = bus.block_out;
        repeat (5) begin
            @(negedge clk);
            check_blk("hold_out", bus.block_out, snap);
            check_bit("hold_last", bus.block_last, 1'b1);
            check_bit("hold_msg_ready", bus.msg_ready, 1'b0);
        end
        bus.block_ready = 1'b1;
        drain("hold");
        exp = '0;
        exp[7:0] = 8'hB4; exp[15:8] = 8'hA5; exp[23:16] = SUF; exp[1087:1080] = 8'h80;
        push_exp(exp, 1'b1);
        send_word(64'h1122_3344_5566_A5B4, 4'd2, 1'b1);
        drain("after_hold");

        // msg_bytes above 8 behaves as 8
        push_exp(mk_block(16), 1'b1);
        send_word(pat_word(0), 4'd12, 1'b0);
        send_word(pat_word(1), 4'd9, 1'b1);
        drain("clamp");

        // Reset mid-block discards the partial block
        for (int n = 0; n < 5; n++) send_word(pat_word(n), 4'd8, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_bit("rstblk_valid", bus.block_valid, 1'b0);
        check_bit("rstblk_dbg", debug_state == 2'd0, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check_bit("rstblk_valid2", bus.block_valid, 1'b0);
        exp = '0;
        exp[7:0] = 8'h61; exp[15:8] = 8'h62; exp[23:16] = 8'h63;
        exp[31:24] = SUF; exp[1087:1080] = 8'h80;
        push_exp(exp, 1'b1);
        send_word(64'h636261, 4'd3, 1'b1);
        drain("rstblk_abc");

        // Reset while a full block is waiting on the consumer
        bus.block_ready = 1'b0;
        for (int n = 0; n < 17; n++) send_word(pat_word(n), 4'd8, 1'b0);
        wait_valid("rstemit");
        check_bit("rstemit_last", bus.block_last, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_bit("rstemit_valid", bus.block_valid, 1'b0);
        check_blk("rstemit_out", bus.block_out, '0);
        reset = 1'b0;
        bus.block_ready = 1'b1;
        @(negedge clk);
        push_exp(mk_block(0), 1'b1);
        send_word(64'h0, 4'd0, 1'b1);
        drain("rstemit_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
